// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the queued RV32 instruction-fetch stage.
package rv32_fetch_pkg;

    localparam logic [31:0] RV32_INSTR_NOP                    = 32'h0000_0013;
    localparam logic [3:0]  RV32_MCAUSE_INSTR_FAULT_EXCEPTION = 4'd1;

    localparam logic [6:0]  RV32_OPCODE_JAL    = 7'b110_1111;
    localparam logic [6:0]  RV32_OPCODE_BRANCH = 7'b110_0011;

    typedef enum int {
        BP_NONE   = 0,
        BP_STATIC = 1
    } bp_mode_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
        logic        pred_taken;
    } fetch_entry_t;

    typedef struct packed {
        logic        epoch;
        logic [31:0] pc;
    } tag_entry_t;

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/rv32_fetch_queue.sv
// Synchronous FIFO of arbitrary entry type with synchronous clear.
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module rv32_fetch_queue #(
    parameter type entry_t = logic [31:0],
    parameter int  DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t           entries [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full queue is accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = entries[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !reset && !clear) begin
            entries[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/rv32_fetch_queued.sv
// Instruction fetch with credit-limited outstanding reads, epoch-tagged responses,
// a prefetch queue, optional static branch prediction and a decode output register.
module rv32_fetch_queued
    import rv32_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR      = 32'h0000_0000,
    parameter int          BRANCH_PREDICTION = 0,
    parameter int          QUEUE_DEPTH       = 4,
    parameter int          MAX_OUTSTANDING   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        trap_in,
    input  logic        branch_mispredicted_in,
    input  logic [31:0] trap_pc_in,
    input  logic [31:0] branch_pc_in,
    output logic        instr_req_out,
    input  logic        instr_req_ready_in,
    output logic [31:0] instr_address_out,
    input  logic        instr_resp_valid_in,
    input  logic [31:0] instr_resp_data_in,
    input  logic        instr_resp_fault_in,
    output logic        valid_out,
    output logic        exception_out,
    output logic [3:0]  exception_cause_out,
    output logic        branch_predicted_taken_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out
);

    localparam int Q_CNT_W   = $clog2(QUEUE_DEPTH) + 1;
    localparam int TAG_DEPTH = (MAX_OUTSTANDING < 2) ? 2 : MAX_OUTSTANDING;
    localparam int TAG_CNT_W = $clog2(TAG_DEPTH) + 1;

    logic [31:0]          pc;
    logic [31:0]          pc_next;
    logic                 epoch;
    logic                 epoch_next;
    logic                 fault_hold;
    logic                 fault_hold_next;

    fetch_entry_t         q_head;
    fetch_entry_t         q_push_data;
    logic [Q_CNT_W-1:0]   q_count;
    logic                 q_empty;
    logic                 q_pop;

    tag_entry_t           tag_head;
    tag_entry_t           tag_push_data;
    logic [TAG_CNT_W-1:0] outstanding;

    logic                 accept;
    logic                 redirect;
    logic                 resp_keep;
    logic                 is_jal;
    logic                 is_branch;
    logic                 pred_taken;
    logic [31:0]          pred_target;

    // The tag FIFO holds exactly one entry per in-flight read, so its count is the outstanding count.
    assign instr_req_out = !reset && !fault_hold
                        && ((32'(outstanding) + 32'(q_count)) < 32'(QUEUE_DEPTH))
                        && (32'(outstanding) < 32'(MAX_OUTSTANDING));
    assign instr_address_out = pc;
    assign accept            = instr_req_out && instr_req_ready_in;
    assign redirect          = trap_in || branch_mispredicted_in;

    assign resp_keep   = instr_resp_valid_in && !redirect && (tag_head.epoch == epoch);
    assign is_jal      = (instr_resp_data_in[6:0] == RV32_OPCODE_JAL);
    assign is_branch   = (instr_resp_data_in[6:0] == RV32_OPCODE_BRANCH);
    assign pred_taken  = (BRANCH_PREDICTION == int'(BP_STATIC)) && resp_keep && !instr_resp_fault_in
                      && (is_jal || (is_branch && instr_resp_data_in[31]));
    assign pred_target = tag_head.pc + (is_jal ? imm_j(instr_resp_data_in) : imm_b(instr_resp_data_in));

    assign tag_push_data = '{epoch: epoch, pc: pc};
    assign q_push_data   = '{instr: instr_resp_data_in, pc: tag_head.pc,
                             fault: instr_resp_fault_in, pred_taken: pred_taken};
    assign q_empty       = (q_count == '0);
    assign q_pop         = !stall_in && !flush_in && !q_empty;

    rv32_fetch_queue #(
        .entry_t (tag_entry_t),
        .DEPTH   (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .push      (accept),
        .push_data (tag_push_data),
        .pop       (instr_resp_valid_in),
        .head      (tag_head),
        .count     (outstanding)
    );

    rv32_fetch_queue #(
        .entry_t (fetch_entry_t),
        .DEPTH   (QUEUE_DEPTH)
    ) u_prefetch_queue (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .push      (resp_keep),
        .push_data (q_push_data),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count)
    );

    // Every PC change toggles the epoch so reads issued on the old path are discarded on return.
    always_comb begin
        pc_next         = pc;
        epoch_next      = epoch;
        fault_hold_next = fault_hold;
        if (trap_in) begin
            pc_next         = trap_pc_in;
            epoch_next      = !epoch;
            fault_hold_next = 1'b0;
        end else if (branch_mispredicted_in) begin
            pc_next         = branch_pc_in;
            epoch_next      = !epoch;
            fault_hold_next = 1'b0;
        end else begin
            if (pred_taken) begin
                pc_next    = pred_target;
                epoch_next = !epoch;
            end else if (accept) begin
                pc_next = pc + 32'd4;
            end
            if (resp_keep && instr_resp_fault_in) begin
                fault_hold_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_VECTOR;
            epoch      <= 1'b0;
            fault_hold <= 1'b0;
        end else begin
            pc         <= pc_next;
            epoch      <= epoch_next;
            fault_hold <= fault_hold_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out                  <= 1'b0;
            exception_out              <= 1'b0;
            exception_cause_out        <= 4'd0;
            branch_predicted_taken_out <= 1'b0;
            pc_out                     <= 32'd0;
            instr_out                  <= RV32_INSTR_NOP;
        end else if (!stall_in) begin
            if (flush_in || q_empty) begin
                valid_out                  <= 1'b0;
                exception_out              <= 1'b0;
                exception_cause_out        <= 4'd0;
                branch_predicted_taken_out <= 1'b0;
                pc_out                     <= 32'd0;
                instr_out                  <= RV32_INSTR_NOP;
            end else begin
                valid_out                  <= !q_head.fault;
                exception_out              <= q_head.fault;
                exception_cause_out        <= q_head.fault ? RV32_MCAUSE_INSTR_FAULT_EXCEPTION : 4'd0;
                branch_predicted_taken_out <= !q_head.fault && q_head.pred_taken;
                pc_out                     <= q_head.pc;
                instr_out                  <= q_head.fault ? RV32_INSTR_NOP : q_head.instr;
            end
        end
    end

endmodule

// File: tb/tb_rv32_fetch_queued.sv
// Scoreboard bench for rv32_fetch_queued: directed scenarios against a memory model
// with programmable latency, per-address instruction overrides and injected faults.
module tb_rv32_fetch_queued;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_in = 1'b0;
    logic        flush_in = 1'b0;
    logic        trap_in = 1'b0;
    logic        branch_mispredicted_in = 1'b0;
    logic [31:0] trap_pc_in = 32'd0;
    logic [31:0] branch_pc_in = 32'd0;
    logic        instr_req_out;
    logic        instr_req_ready_in = 1'b1;
    logic [31:0] instr_address_out;
    logic        instr_resp_valid_in = 1'b0;
    logic [31:0] instr_resp_data_in = 32'd0;
    logic        instr_resp_fault_in = 1'b0;
    logic        valid_out;
    logic        exception_out;
    logic [3:0]  exception_cause_out;
    logic        branch_predicted_taken_out;
    logic [31:0] pc_out;
    logic [31:0] instr_out;

    always #5 clk = ~clk;

    rv32_fetch_queued #(
        .RESET_VECTOR      (32'h0000_0000),
        .BRANCH_PREDICTION (1),
        .QUEUE_DEPTH       (4),
        .MAX_OUTSTANDING   (2)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .stall_in                   (stall_in),
        .flush_in                   (flush_in),
        .trap_in                    (trap_in),
        .branch_mispredicted_in     (branch_mispredicted_in),
        .trap_pc_in                 (trap_pc_in),
        .branch_pc_in               (branch_pc_in),
        .instr_req_out              (instr_req_out),
        .instr_req_ready_in         (instr_req_ready_in),
        .instr_address_out          (instr_address_out),
        .instr_resp_valid_in        (instr_resp_valid_in),
        .instr_resp_data_in         (instr_resp_data_in),
        .instr_resp_fault_in        (instr_resp_fault_in),
        .valid_out                  (valid_out),
        .exception_out              (exception_out),
        .exception_cause_out        (exception_cause_out),
        .branch_predicted_taken_out (branch_predicted_taken_out),
        .pc_out                     (pc_out),
        .instr_out                  (instr_out)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
        logic        pred;
    } exp_entry_t;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;

    exp_entry_t  exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] mem_img [logic [31:0]];
    bit          fault_map [logic [31:0]];
    int          mem_latency = 1;
    int          mem_cycle = 0;
    int          checks = 0;
    int          errors = 0;

    // Memory: in-order responses, fixed latency, data defaults to the address itself.
    pend_t       mem_p;
    logic [31:0] mem_addr;
    always @(negedge clk) begin
        mem_cycle++;
        instr_resp_valid_in = 1'b0;
        instr_resp_data_in  = 32'd0;
        instr_resp_fault_in = 1'b0;
        if (reset) begin
            pend_q.delete();
        end else begin
            if (pend_q.size() > 0 && pend_q[0].due <= mem_cycle) begin
                mem_addr = pend_q[0].addr;
                void'(pend_q.pop_front());
                instr_resp_valid_in = 1'b1;
                instr_resp_data_in  = mem_img.exists(mem_addr) ? mem_img[mem_addr] : mem_addr;
                instr_resp_fault_in = fault_map.exists(mem_addr);
            end
            if (instr_req_out && instr_req_ready_in) begin
                mem_p.due  = mem_cycle + mem_latency;
                mem_p.addr = instr_address_out;
                pend_q.push_back(mem_p);
            end
        end
    end

    // Monitor: every freshly loaded valid or faulting output consumes one expected entry.
    logic        stall_at_edge = 1'b0;
    exp_entry_t  mon_e;
    logic [70:0] mon_got;
    logic [70:0] mon_want;
    always @(posedge clk) stall_at_edge <= stall_in;

    always @(negedge clk) begin
        if (!reset && !stall_at_edge && (valid_out === 1'b1 || exception_out === 1'b1)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_output: got pc=%h instr=%h valid=%b exc=%b, required no output",
                         pc_out, instr_out, valid_out, exception_out);
            end else begin
                mon_e    = exp_q.pop_front();
                mon_got  = {valid_out, exception_out, exception_cause_out, branch_predicted_taken_out, pc_out, instr_out};
                mon_want = {!mon_e.exc, mon_e.exc, (mon_e.exc ? 4'h1 : 4'h0), mon_e.pred, mon_e.pc, mon_e.instr};
                if (mon_got !== mon_want) begin
                    errors++;
                    $display("[TB] FAIL fetch_out: got v=%b e=%b c=%h p=%b pc=%h i=%h, required v=%b e=%b c=%h p=%b pc=%h i=%h",
                             mon_got[70], mon_got[69], mon_got[68:65], mon_got[64], mon_got[63:32], mon_got[31:0],
                             mon_want[70], mon_want[69], mon_want[68:65], mon_want[64], mon_want[63:32], mon_want[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic expectOut(input logic [31:0] pc, input logic [31:0] instr, input logic exc, input logic pred);
        exp_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        e.exc   = exc;
        e.pred  = pred;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic stall, input logic flush, input logic trap,
                                 input logic mispredict, input logic [31:0] trap_pc, input logic [31:0] branch_pc);
        stall_in               = stall;
        flush_in               = flush;
        trap_in                = trap;
        branch_mispredicted_in = mispredict;
        trap_pc_in             = trap_pc;
        branch_pc_in           = branch_pc;
    endtask

    task automatic applyReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
    endtask

    // Wait (bounded) for the scoreboard to empty, then freeze the output register.
    task automatic drainAndHold(input string name);
        int n = 0;
        #1;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        stall_in = 1'b1;
        checkOutput(name, exp_q.size(), 32'd0);
        repeat (3) step();
    endtask

    initial begin
        int consec;

        // Reset values and sequential fetch with 1-cycle memory
        $display("[TB] scenario: reset and sequential fetch");
        mem_latency = 1;
        reset = 1'b1;
        step();
        step();
        @(negedge clk);
        checkOutput("rst_req", instr_req_out, 32'd0);
        checkOutput("rst_addr", instr_address_out, 32'h0);
        checkOutput("rst_valid", valid_out, 32'd0);
        checkOutput("rst_exc", exception_out, 32'd0);
        checkOutput("rst_cause", exception_cause_out, 32'd0);
        checkOutput("rst_pred", branch_predicted_taken_out, 32'd0);
        checkOutput("rst_pc", pc_out, 32'd0);
        checkOutput("rst_instr", instr_out, 32'h0000_0013);
        step();
        reset = 1'b0;
        for (int a = 0; a < 32; a += 4) expectOut(a, a, 1'b0, 1'b0);
        repeat (2) step();
        @(negedge clk);
        checkOutput("seq_valid_cycle2", valid_out, 32'd0);
        step();
        @(negedge clk);
        checkOutput("seq_valid_cycle3", valid_out, 32'd1);
        checkOutput("seq_pc_cycle3", pc_out, 32'h0);
        consec = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            @(negedge clk);
            if (valid_out === 1'b1) consec++;
        end
        checkOutput("seq_throughput", consec, 32'd7);
        drainAndHold("seq_drain");

        // Trap while two 3-cycle reads are in flight
        $display("[TB] scenario: trap redirect");
        mem_latency = 3;
        applyReset();
        for (int a = 32'h100; a <= 32'h10C; a += 4) expectOut(a, a, 1'b0, 1'b0);
        step();
        @(negedge clk);
        checkOutput("trap_req_cycle1", instr_req_out, 32'd1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'd0);
        @(negedge clk);
        checkOutput("trap_max_outstanding", instr_req_out, 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput("trap_new_addr", instr_address_out, 32'h100);
        drainAndHold("trap_drain");

        // Backward BEQ at 0x10 (imm -8) predicted taken
        $display("[TB] scenario: static prediction");
        mem_latency = 1;
        mem_img[32'h10] = 32'hFE00_0CE3;
        applyReset();
        expectOut(32'h00, 32'h00, 1'b0, 1'b0);
        expectOut(32'h04, 32'h04, 1'b0, 1'b0);
        expectOut(32'h08, 32'h08, 1'b0, 1'b0);
        expectOut(32'h0C, 32'h0C, 1'b0, 1'b0);
        expectOut(32'h10, 32'hFE00_0CE3, 1'b0, 1'b1);
        expectOut(32'h08, 32'h08, 1'b0, 1'b0);
        expectOut(32'h0C, 32'h0C, 1'b0, 1'b0);
        expectOut(32'h10, 32'hFE00_0CE3, 1'b0, 1'b1);
        expectOut(32'h08, 32'h08, 1'b0, 1'b0);
        repeat (6) step();
        @(negedge clk);
        checkOutput("pred_target_addr", instr_address_out, 32'h08);
        drainAndHold("pred_drain");
        mem_img.delete();

        // Fault on 0x8; its word is a JAL that must not be predicted
        $display("[TB] scenario: fetch fault");
        mem_img[32'h8]   = 32'h0000_006F;
        fault_map[32'h8] = 1'b1;
        applyReset();
        expectOut(32'h00, 32'h00, 1'b0, 1'b0);
        expectOut(32'h04, 32'h04, 1'b0, 1'b0);
        expectOut(32'h08, 32'h0000_0013, 1'b1, 1'b0);
        expectOut(32'h0C, 32'h0C, 1'b0, 1'b0);
        expectOut(32'h40, 32'h40, 1'b0, 1'b0);
        expectOut(32'h44, 32'h44, 1'b0, 1'b0);
        expectOut(32'h48, 32'h48, 1'b0, 1'b0);
        repeat (4) step();
        for (int c = 4; c < 10; c++) begin
            @(negedge clk);
            checkOutput($sformatf("fault_hold_req_c%0d", c), instr_req_out, 32'd0);
            step();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h40);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput("fault_resume_req", instr_req_out, 32'd1);
        checkOutput("fault_resume_addr", instr_address_out, 32'h40);
        drainAndHold("fault_drain");
        mem_img.delete();
        fault_map.delete();

        // Long stall until the queue fills, then a single flush bubble
        $display("[TB] scenario: stall and flush");
        applyReset();
        for (int a = 0; a < 48; a += 4) expectOut(a, a, 1'b0, 1'b0);
        repeat (4) step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int c = 4; c < 12; c++) begin
            @(negedge clk);
            checkOutput($sformatf("stall_valid_c%0d", c), valid_out, 32'd1);
            checkOutput($sformatf("stall_pc_c%0d", c), pc_out, 32'h4);
            if (c >= 7) checkOutput($sformatf("stall_full_req_c%0d", c), instr_req_out, 32'd0);
            step();
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput("flush_valid", valid_out, 32'd0);
        checkOutput("flush_pc", pc_out, 32'd0);
        checkOutput("flush_instr", instr_out, 32'h0000_0013);
        drainAndHold("flush_drain");

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
